usb_frame_demux: RTL and testbench

Parametrised successor to the single-stream USB3 word cache. It sits between the USB3 slave-FIFO read path and the per-channel delay/playback RAMs. It parses framed 32-bit words arriving during read bursts and routes each frame's payload into a ping-pong bank pair for its channel. It flags each completed bank to the consumer side and reports sync, length and overflow errors instead of silently corrupting RAM contents.

---
 rtl/usb_demux_pkg.sv | 30 +++
 rtl/usb_frame_demux_if.sv | 44 ++++
 rtl/demux_bank_tracker.sv | 71 +++++++
 rtl/usb_frame_demux.sv | 265 ++++++++++++++++++++++++++
 tb/tb_usb_frame_demux.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : usb_demux_pkg
//  Description : Shared constants and types for the USB3 frame demultiplexer.
//                Header layout of a 32-bit frame header word:
//                  [SYNC_MSB -: SYNC_W] sync byte
//                  [CH_MSB   -: CH_W  ] destination channel
//                  [LEN_MSB  -: LEN_W ] payload word count
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_demux_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    localparam int SYNC_MSB = 31;
    localparam int SYNC_W   = 8;
    localparam int CH_MSB   = 23;
    localparam int CH_W     = 8;
    localparam int LEN_MSB  = 15;
    localparam int LEN_W    = 16;

    // Parser states: looking for a header, writing payload, discarding payload.
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } demux_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_frame_demux_if.sv
`default_nettype none
// ============================================================================
//  Interface   : usb_frame_demux_if
//  Description : Bundles the word input, bank write port, bank status and
//                error reporting of usb_frame_demux.
//                  master : upstream FIFO reader / consumer side (drives
//                           in_valid, in_data, bank_release)
//                  slave  : the demultiplexer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface usb_frame_demux_if #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) ();

    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic [2*N_CH-1:0]   bank_release;

    logic [2*N_CH-1:0]   wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [2*N_CH-1:0]   bank_ready;
    logic                err_sync;
    logic                err_len;
    logic                err_ovf;
    logic [15:0]         drop_cnt;
    logic                busy;

    modport master (
        output in_valid, in_data, bank_release,
        input  wr_en, wr_addr, wr_data, bank_ready,
        input  err_sync, err_len, err_ovf, drop_cnt, busy
    );

    modport slave (
        input  in_valid, in_data, bank_release,
        output wr_en, wr_addr, wr_data, bank_ready,
        output err_sync, err_len, err_ovf, drop_cnt, busy
    );

endinterface
`default_nettype wire

// File: rtl/demux_bank_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : demux_bank_tracker
//  Description : Per-channel ping-pong bookkeeping. Holds the wr_bank toggle
//                of every channel and the bank_ready flag of every bank
//                (index ch*2+bank).
//  Ports       : clk, rst           clock, synchronous active-high reset
//                i_set_req          frame on (i_set_ch, i_set_bank) completed
//                i_set_ch/_bank     bank that just received its last word
//                i_bank_release     consumer release pulses, one per bank
//                o_wr_bank          current write bank per channel
//                o_bank_ready       bank holds a complete, unconsumed frame
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_bank_tracker #(
    parameter int N_CH     = 8,
    parameter int CH_IDX_W = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_set_req,
    input  wire logic [CH_IDX_W-1:0]   i_set_ch,
    input  wire logic                  i_set_bank,
    input  wire logic [2*N_CH-1:0]     i_bank_release,
    output      logic [N_CH-1:0]       o_wr_bank,
    output      logic [2*N_CH-1:0]     o_bank_ready
);

    localparam int BANKS      = 2 * N_CH;
    localparam int BANK_IDX_W = CH_IDX_W + 1;

    logic [N_CH-1:0]       r_wr_bank;
    logic [BANKS-1:0]      r_bank_ready;
    logic                  r_pend;
    logic [BANK_IDX_W-1:0] r_pend_idx;
    logic [BANKS-1:0]      w_set_mask;

    // The toggle flips on the edge that samples the last payload word so a
    // header arriving on the very next word already targets the other bank.
    // The ready flag is delayed one more edge so it rises only after the
    // final write strobe has been presented to the RAM.
    always_comb begin
        w_set_mask = '0;
        if (r_pend) begin
            w_set_mask = {{(BANKS-1){1'b0}}, 1'b1} << r_pend_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank    <= '0;
            r_bank_ready <= '0;
            r_pend       <= 1'b0;
            r_pend_idx   <= '0;
        end else begin
            if (i_set_req) begin
                r_wr_bank[i_set_ch] <= ~r_wr_bank[i_set_ch];
            end
            r_pend       <= i_set_req;
            r_pend_idx   <= {i_set_ch, i_set_bank};
            // A set and a release never hit the same bit, so the order of
            // clear-then-set only matters for unrelated bits.
            r_bank_ready <= (r_bank_ready & ~i_bank_release) | w_set_mask;
        end
    end

    assign o_wr_bank    = r_wr_bank;
    assign o_bank_ready = r_bank_ready;

endmodule
`default_nettype wire

// File: rtl/usb_frame_demux.sv
`default_nettype none
// ============================================================================
//  Module      : usb_frame_demux
//  Description : Parses framed words from the USB3 slave-FIFO read path and
//                routes each frame's payload into the ping-pong bank pair of
//                its channel. Bad headers and frames for full banks are
//                reported instead of being written.
//  Ports       : clk              single clock
//                rst              synchronous active-high reset
//                bus (slave)      in_valid, in_data, bank_release in;
//                                 wr_en, wr_addr, wr_data, bank_ready,
//                                 err_sync, err_len, err_ovf, drop_cnt,
//                                 busy out (all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_frame_demux
    import usb_demux_pkg::*;
#(
    parameter int               N_CH   = 8,
    parameter int               DATA_W = 32,
    parameter int               DEPTH  = 256,
    parameter int               ADDR_W = $clog2(DEPTH),
    parameter logic [SYNC_W-1:0] SYNC  = SYNC_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    usb_frame_demux_if.slave bus
);

    localparam int BANKS      = 2 * N_CH;
    localparam int CH_IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BANK_IDX_W = CH_IDX_W + 1;
    localparam int CNT_W      = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // Header field decode (only meaningful while hunting)
    // ------------------------------------------------------------------
    logic [SYNC_W-1:0]   w_hdr_sync;
    logic [CH_W-1:0]     w_hdr_ch;
    logic [LEN_W-1:0]    w_hdr_len;
    logic                w_sync_ok;
    logic                w_ch_ok;
    logic                w_len_ok;
    logic                w_hdr_good;
    logic [CH_IDX_W-1:0] w_ch_idx;
    logic                w_hdr_bank;
    logic                w_hdr_full;

    logic [N_CH-1:0]     w_wr_bank;
    logic [BANKS-1:0]    w_bank_ready;

    assign w_hdr_sync = bus.in_data[SYNC_MSB -: SYNC_W];
    assign w_hdr_ch   = bus.in_data[CH_MSB -: CH_W];
    assign w_hdr_len  = bus.in_data[LEN_MSB -: LEN_W];

    assign w_sync_ok  = (w_hdr_sync == SYNC);
    assign w_ch_ok    = ({{(32-CH_W){1'b0}}, w_hdr_ch} < 32'(N_CH));
    assign w_len_ok   = (w_hdr_len != '0) &&
                        ({{(32-LEN_W){1'b0}}, w_hdr_len} <= 32'(DEPTH));
    assign w_hdr_good = w_sync_ok && w_ch_ok && w_len_ok;

    // Truncation is safe: the bank lookup is only acted on when w_ch_ok.
    assign w_ch_idx   = w_hdr_ch[CH_IDX_W-1:0];
    assign w_hdr_bank = w_wr_bank[w_ch_idx];
    assign w_hdr_full = w_bank_ready[{w_ch_idx, w_hdr_bank}];

    // ------------------------------------------------------------------
    // Frame context
    // ------------------------------------------------------------------
    demux_state_t          r_state;
    demux_state_t          w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [CH_IDX_W-1:0]   r_ch;
    logic                  r_bank;
    logic                  w_cnt_last;
    logic [BANK_IDX_W-1:0] w_wr_idx;
    logic [BANKS-1:0]      w_wr_onehot;

    assign w_cnt_last  = (r_cnt == CNT_W'(1));
    assign w_wr_idx    = {r_ch, r_bank};
    assign w_wr_onehot = {{(BANKS-1){1'b0}}, 1'b1} << w_wr_idx;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.in_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (w_hdr_good) begin
                        w_state_nxt = w_hdr_full ? DROP : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (w_cnt_last) begin
                        w_state_nxt = HUNT;
                    end
                end
                DROP: begin
                    if (w_cnt_last) begin
                        w_state_nxt = HUNT;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: control outputs
    // ------------------------------------------------------------------
    logic w_err_sync_set;
    logic w_err_len_set;
    logic w_err_ovf_set;
    logic w_load_frame;
    logic w_load_drop;
    logic w_wr_fire;
    logic w_cnt_dec;
    logic w_set_req;

    always_comb begin
        w_err_sync_set = 1'b0;
        w_err_len_set  = 1'b0;
        w_err_ovf_set  = 1'b0;
        w_load_frame   = 1'b0;
        w_load_drop    = 1'b0;
        w_wr_fire      = 1'b0;
        w_cnt_dec      = 1'b0;
        w_set_req      = 1'b0;
        if (bus.in_valid) begin
            unique case (r_state)
                HUNT: begin
                    // A bad length is never trusted, so nothing is skipped:
                    // the next word is examined as a potential header.
                    if (!w_sync_ok) begin
                        w_err_sync_set = 1'b1;
                    end else if (!w_ch_ok || !w_len_ok) begin
                        w_err_len_set = 1'b1;
                    end else if (w_hdr_full) begin
                        w_err_ovf_set = 1'b1;
                        w_load_drop   = 1'b1;
                    end else begin
                        w_load_frame = 1'b1;
                    end
                end
                PAYLOAD: begin
                    w_wr_fire = 1'b1;
                    if (w_cnt_last) begin
                        w_set_req = 1'b1;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                DROP: begin
                    if (!w_cnt_last) begin
                        w_cnt_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write datapath and registered status
    // ------------------------------------------------------------------
    logic [BANKS-1:0]  r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_err_sync;
    logic              r_err_len;
    logic              r_err_ovf;
    logic [15:0]       r_drop_cnt;
    logic              r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_ch       <= '0;
            r_bank     <= 1'b0;
            r_wr_en    <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_err_sync <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_drop_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_err_sync <= w_err_sync_set;
            r_err_len  <= w_err_len_set;
            r_err_ovf  <= w_err_ovf_set;
            r_busy     <= (w_state_nxt != HUNT);

            if (w_load_frame || w_load_drop) begin
                r_cnt <= CNT_W'(w_hdr_len);
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_load_frame) begin
                r_ch   <= w_ch_idx;
                r_bank <= w_hdr_bank;
                r_addr <= '0;
            end else if (w_wr_fire) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            // Address and data hold their last value between strobes.
            r_wr_en <= '0;
            if (w_wr_fire) begin
                r_wr_en   <= w_wr_onehot;
                r_wr_addr <= r_addr;
                r_wr_data <= bus.in_data;
            end

            if (w_err_ovf_set && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank bookkeeping
    // ------------------------------------------------------------------
    demux_bank_tracker #(
        .N_CH     (N_CH),
        .CH_IDX_W (CH_IDX_W)
    ) u_tracker (
        .clk            (clk),
        .rst            (rst),
        .i_set_req      (w_set_req),
        .i_set_ch       (r_ch),
        .i_set_bank     (r_bank),
        .i_bank_release (bus.bank_release),
        .o_wr_bank      (w_wr_bank),
        .o_bank_ready   (w_bank_ready)
    );

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.bank_ready = w_bank_ready;
    assign bus.err_sync   = r_err_sync;
    assign bus.err_len    = r_err_len;
    assign bus.err_ovf    = r_err_ovf;
    assign bus.drop_cnt   = r_drop_cnt;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_usb_frame_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_frame_demux
//  Description : Self-checking bench for usb_frame_demux. A behavioural model
//                turns every driven word into expected writes and error
//                pulses; a monitor compares them against the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_frame_demux;
    import usb_demux_pkg::*;

    localparam int N_CH   = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int BANKS  = 2 * N_CH;
    localparam logic [7:0] SYNC = SYNC_DEFAULT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    usb_frame_demux_if #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    usb_frame_demux #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .SYNC   (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          idx;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_exp_t;

    typedef struct {
        logic [2:0] kind;   // {sync, len, ovf}
        int         drop;
        int         cyc;
    } err_exp_t;

    wr_exp_t  q_wr[$];
    err_exp_t q_err[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: frame rules applied word by word
    // ------------------------------------------------------------------
    int m_mode;            // 0 = looking for header, 1 = storing, 2 = discarding
    int m_rem;
    int m_idx;
    int m_addr;
    int m_drop;
    int m_wrbank[N_CH];
    bit m_ready[BANKS];

    function automatic void model_reset();
        m_mode = 0; m_rem = 0; m_idx = 0; m_addr = 0; m_drop = 0;
        for (int i = 0; i < N_CH; i++) m_wrbank[i] = 0;
        for (int i = 0; i < BANKS; i++) m_ready[i] = 1'b0;
    endfunction

    function automatic logic [BANKS-1:0] model_vec();
        logic [BANKS-1:0] v;
        v = '0;
        for (int i = 0; i < BANKS; i++) v[i] = m_ready[i];
        return v;
    endfunction

    function automatic void push_err(input logic [2:0] k);
        err_exp_t e;
        e.kind = k; e.drop = m_drop; e.cyc = cyc + 1;
        q_err.push_back(e);
    endfunction

    function automatic void model_word(input logic [31:0] d);
        int ch, len;
        wr_exp_t w;
        case (m_mode)
            0: begin
                ch  = int'(d[23:16]);
                len = int'(d[15:0]);
                if (d[31:24] != SYNC) begin
                    push_err(3'b100);
                end else if (ch >= N_CH || len == 0 || len > DEPTH) begin
                    push_err(3'b010);
                end else if (m_ready[2*ch + m_wrbank[ch]]) begin
                    if (m_drop < 65535) m_drop++;
                    push_err(3'b001);
                    m_mode = 2; m_rem = len;
                end else begin
                    m_mode = 1; m_idx = 2*ch + m_wrbank[ch]; m_addr = 0; m_rem = len;
                end
            end
            1: begin
                w.idx = m_idx; w.addr = m_addr; w.data = d; w.cyc = cyc + 1;
                q_wr.push_back(w);
                m_addr++; m_rem--;
                if (m_rem == 0) begin
                    m_ready[m_idx] = 1'b1;
                    m_wrbank[m_idx/2] = 1 - m_wrbank[m_idx/2];
                    m_mode = 0;
                end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) m_mode = 0;
            end
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Monitor: pops expectations whenever the DUT presents an output
    // ------------------------------------------------------------------
    always @(negedge clk) begin : mon
        wr_exp_t    we;
        err_exp_t   ee;
        logic [2:0] errv;
        if (bus.wr_en !== '0) begin
            if (q_wr.size() == 0) begin
                chk("unexpected_wr_en", 64'(bus.wr_en), 64'd0);
            end else begin
                we = q_wr.pop_front();
                chk("wr_en",   64'(bus.wr_en),   64'd1 << we.idx);
                chk("wr_addr", 64'(bus.wr_addr), 64'(we.addr));
                chk("wr_data", 64'(bus.wr_data), 64'(we.data));
                chk("wr_cycle", 64'(cyc), 64'(we.cyc));
            end
        end
        errv = {bus.err_sync, bus.err_len, bus.err_ovf};
        if (errv !== 3'b000) begin
            if (q_err.size() == 0) begin
                chk("unexpected_err", 64'(errv), 64'd0);
            end else begin
                ee = q_err.pop_front();
                chk("err_kind",  64'(errv), 64'(ee.kind));
                chk("err_cycle", 64'(cyc),  64'(ee.cyc));
                if (ee.kind == 3'b001) chk("drop_cnt_at_ovf", 64'(bus.drop_cnt), 64'(ee.drop));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] hdr(input int ch, input int len);
        return {SYNC, 8'(ch), 16'(len)};
    endfunction

    task automatic drive_word(input logic [31:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        model_word(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
        end
    endtask

    // base < 0 selects random payload, otherwise base, base+1, ...
    task automatic send_frame(input int ch, input int len, input int gap, input int base);
        drive_word(hdr(ch, len));
        for (int i = 0; i < len; i++) begin
            if (gap > 0) idle(gap);
            drive_word(base < 0 ? $urandom : 32'(base + i));
        end
    endtask

    task automatic release_bits(input logic [BANKS-1:0] mask);
        @(negedge clk);
        bus.in_valid     = 1'b0;
        bus.bank_release = mask;
        for (int i = 0; i < BANKS; i++) if (mask[i]) m_ready[i] = 1'b0;
        @(negedge clk);
        bus.bank_release = '0;
    endtask

    task automatic quiesce_check(input string tag);
        idle(3);
        chk({tag, "_bank_ready"}, 64'(bus.bank_ready), 64'(model_vec()));
        chk({tag, "_drop_cnt"},   64'(bus.drop_cnt),   64'(m_drop));
        chk({tag, "_busy"},       64'(bus.busy),       64'd0);
        chk({tag, "_wr_pending"}, 64'(q_wr.size()),    64'd0);
        chk({tag, "_err_pending"},64'(q_err.size()),   64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wr_en"},      64'(bus.wr_en),      64'd0);
        chk({tag, "_wr_addr"},    64'(bus.wr_addr),    64'd0);
        chk({tag, "_wr_data"},    64'(bus.wr_data),    64'd0);
        chk({tag, "_bank_ready"}, 64'(bus.bank_ready), 64'd0);
        chk({tag, "_err"},        64'({bus.err_sync, bus.err_len, bus.err_ovf}), 64'd0);
        chk({tag, "_drop_cnt"},   64'(bus.drop_cnt),   64'd0);
        chk({tag, "_busy"},       64'(bus.busy),       64'd0);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.bank_release = '0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        idle(2);

        // Nominal frame to ch3: bank 0 (bit 6), then next ch3 frame on bit 7
        send_frame(3, 4, 0, 10);
        @(negedge clk); bus.in_valid = 1'b0;
        chk("nominal_ready6_before", 64'(bus.bank_ready[6]), 64'd0);
        @(negedge clk);
        chk("nominal_ready6_after", 64'(bus.bank_ready[6]), 64'd1);
        send_frame(3, 2, 0, -1);
        quiesce_check("nominal");
        release_bits(model_vec());

        // Back-to-back frames to ch1 then ch2, no idle cycles
        drive_word(hdr(1, 3));
        for (int i = 0; i < 3; i++) drive_word($urandom);
        drive_word(hdr(2, 2));
        chk("b2b_ready2_before", 64'(bus.bank_ready[2]), 64'd0);
        drive_word($urandom);
        chk("b2b_ready2_after", 64'(bus.bank_ready[2]), 64'd1);
        drive_word($urandom);
        @(negedge clk); bus.in_valid = 1'b0;
        chk("b2b_ready4_before", 64'(bus.bank_ready[4]), 64'd0);
        @(negedge clk);
        chk("b2b_ready4_after", 64'(bus.bank_ready[4]), 64'd1);
        quiesce_check("b2b");
        release_bits(model_vec());

        // Bad sync, bad channel, bad length, then a good frame
        drive_word(32'h5A00_0001);
        drive_word(32'hA509_0001);
        drive_word(32'hA500_0101);
        send_frame(0, 1, 0, -1);
        quiesce_check("badhdr");
        release_bits(model_vec());

        // Overflow on ch0
        send_frame(0, 2, 0, -1);
        send_frame(0, 2, 0, -1);
        send_frame(0, 2, 0, -1);
        quiesce_check("ovf");
        chk("ovf_drop_cnt_one", 64'(bus.drop_cnt), 64'd1);
        release_bits(16'h0001);
        send_frame(0, 2, 0, -1);
        quiesce_check("ovf_after_release");
        release_bits(model_vec());

        // Gapped frame to ch6
        drive_word(hdr(6, 3));
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < 5; g++) begin
                idle(1);
                chk("gap_busy", 64'(bus.busy), 64'd1);
            end
            drive_word($urandom);
        end
        quiesce_check("gap");

        // Maximum length frame, addresses 0..DEPTH-1
        send_frame(4, DEPTH, 0, 1000);
        quiesce_check("maxlen");
        release_bits(model_vec());

        // Reset in the middle of a frame to ch5
        send_frame(5, 1, 0, -1);
        drive_word(hdr(5, 4));
        drive_word($urandom);
        drive_word($urandom);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        rst = 1'b0;
        model_reset();
        send_frame(5, 2, 0, -1);
        quiesce_check("midreset_after");
        release_bits(model_vec());

        // Randomised traffic
        for (int f = 0; f < 250; f++) begin
            int r, ch, len, gap;
            logic [31:0] w;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                w = $urandom;
                if (w[31:24] == SYNC) w[31:24] = ~SYNC;
                drive_word(w);
            end else if (r == 1) begin
                case ($urandom_range(0, 2))
                    0:       w = hdr($urandom_range(N_CH, 255), 1);
                    1:       w = hdr($urandom_range(0, N_CH-1), 0);
                    default: w = hdr($urandom_range(0, N_CH-1), $urandom_range(DEPTH+1, 65535));
                endcase
                drive_word(w);
            end else begin
                ch  = $urandom_range(0, N_CH-1);
                len = $urandom_range(1, 6);
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                send_frame(ch, len, gap, -1);
            end
            if ($urandom_range(0, 3) == 0) begin
                idle(2);
                release_bits(model_vec() & BANKS'($urandom));
            end else begin
                idle($urandom_range(0, 2));
            end
        end
        quiesce_check("random_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
